// File: rtl/adder_pipeline_chain.sv
// ----------------------------------------------------------------------------
// adder_pipeline_chain
//   Pipelined ripple-carry adder. The WIDTH-bit addition a0 + a1 is cut into
//   STAGES slices of SLICE = ceil(WIDTH/STAGES) bits. The last slice takes the
//   remaining bits. Each slice is added in its own cycle, and the carry is
//   registered between slices. The upper operand bits that are still
//   unprocessed travel forward in skew registers. The finished low sum bits
//   travel forward in deskew registers. A valid/ready handshake is used on
//   both sides, giving a throughput of one add per cycle and a latency of
//   STAGES cycles.
//
//   Optional feature macro: ADDER_PIPE_OVF_EN adds the signed-overflow port
//   ovf.
//
// Ports
//   CLK        in   1        clock, rising edge
//   RST        in   1        asynchronous reset, active-low
//   in_valid   in   1        a0/a1 valid this cycle
//   in_ready   out  1        block accepts a0/a1 this cycle
//   a0, a1     in   WIDTH    unsigned operands
//   out_valid  out  1        sum valid
//   out_ready  in   1        consumer takes sum this cycle
//   sum        out  WIDTH+1  a0 + a1, MSB is the final carry-out
//   ovf        out  1        two's-complement overflow (ADDER_PIPE_OVF_EN only)
// ----------------------------------------------------------------------------
module adder_pipeline_chain #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
`ifdef ADDER_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int SLICE = (WIDTH + STAGES - 1) / STAGES;

  logic w_stall;
  logic w_unused_skew;

  // A full output that the consumer does not take freezes every stage.
  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Bit range [LO, HI) that this stage adds. It is empty when the slices run out early.
    localparam int LO = k * SLICE;
    localparam int HI = ((k + 1) * SLICE > WIDTH) ? WIDTH : (k + 1) * SLICE;

    logic             w_v_in;
    logic             w_c_in;
    logic             w_c;
    logic [WIDTH-1:0] w_a0;
    logic [WIDTH-1:0] w_a1;
    logic [WIDTH-1:0] w_ps_in;
    logic [WIDTH-1:0] w_ps;

    logic             r_v;
    logic             r_c;
    logic [WIDTH-1:0] r_ps;
    logic [WIDTH-1:0] r_a0;
    logic [WIDTH-1:0] r_a1;
`ifdef ADDER_PIPE_OVF_EN
    logic             w_cm_in;
    logic             w_cm;
    logic             r_cm;
`endif

    if (k == 0) begin : g_head
      assign w_v_in  = in_valid;
      assign w_c_in  = 1'b0;
      assign w_a0    = a0;
      assign w_a1    = a1;
      assign w_ps_in = {WIDTH{1'b0}};
`ifdef ADDER_PIPE_OVF_EN
      assign w_cm_in = 1'b0;
`endif
    end else begin : g_body
      assign w_v_in  = g_stage[k-1].r_v;
      assign w_c_in  = g_stage[k-1].r_c;
      assign w_a0    = g_stage[k-1].r_a0;
      assign w_a1    = g_stage[k-1].r_a1;
      assign w_ps_in = g_stage[k-1].r_ps;
`ifdef ADDER_PIPE_OVF_EN
      assign w_cm_in = g_stage[k-1].r_cm;
`endif
    end

    // Ripple through this stage's slice. Bits outside the slice pass through unchanged.
    always_comb begin
      w_ps = w_ps_in;
      w_c  = w_c_in;
`ifdef ADDER_PIPE_OVF_EN
      w_cm = w_cm_in;
`endif
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= LO && i < HI) begin
`ifdef ADDER_PIPE_OVF_EN
          // Remember the carry into the MSB for the overflow flag.
          if (i == WIDTH - 1) begin
            w_cm = w_c;
          end else begin
            w_cm = w_cm;
          end
`endif
          w_ps[i] = w_a0[i] ^ w_a1[i] ^ w_c;
          w_c     = (w_a0[i] & w_a1[i]) | (w_c & (w_a0[i] ^ w_a1[i]));
        end else begin
          w_ps[i] = w_ps_in[i];
        end
      end
    end

    // Stage register: advances together with the whole pipe, holds under stall.
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        r_v  <= 1'b0;
        r_c  <= 1'b0;
        r_ps <= {WIDTH{1'b0}};
        r_a0 <= {WIDTH{1'b0}};
        r_a1 <= {WIDTH{1'b0}};
`ifdef ADDER_PIPE_OVF_EN
        r_cm <= 1'b0;
`endif
      end else if (!w_stall) begin
        r_v  <= w_v_in;
        r_c  <= w_c;
        r_ps <= w_ps;
        r_a0 <= w_a0;
        r_a1 <= w_a1;
`ifdef ADDER_PIPE_OVF_EN
        r_cm <= w_cm;
`endif
      end else begin
        r_v  <= r_v;
        r_c  <= r_c;
        r_ps <= r_ps;
        r_a0 <= r_a0;
        r_a1 <= r_a1;
`ifdef ADDER_PIPE_OVF_EN
        r_cm <= r_cm;
`endif
      end
    end
  end

  // The last stage register is the output register.
  assign out_valid = g_stage[STAGES-1].r_v;
  assign sum       = {g_stage[STAGES-1].r_c, g_stage[STAGES-1].r_ps};

`ifdef ADDER_PIPE_OVF_EN
  // Both terms are flops of the last stage, so ovf stays aligned with sum and holds under stall.
  assign ovf = g_stage[STAGES-1].r_cm ^ g_stage[STAGES-1].r_c;
`endif

  // The last stage's operand copies have no consumer. Synthesis removes them.
  assign w_unused_skew = ^{g_stage[STAGES-1].r_a0, g_stage[STAGES-1].r_a1};

endmodule
